alu_issue_seq: RTL and testbench

//  Issue side of the ALU interface: accepts MIPS R-type instruction words, reads rs/rt from an

---
 rtl/alu_issue_seq_pkg.sv | 75 +++++++
 rtl/alu_issue_seq_if.sv | 31 +++
 rtl/alu_issue_seq_regfile.sv | 34 +++
 rtl/alu_issue_seq.sv | 152 +++++++++++++++
 tb/tb_alu_issue_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer.
// Contains the supported ALU function codes, the sequencer state type,
// and small helpers that slice fields out of an R-type instruction word.
package alu_seq_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_PARK = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic logic [5:0] instr_op(input logic [31:0] w);
    return w[31:26];
  endfunction

  function automatic logic [4:0] instr_rs(input logic [31:0] w);
    return w[25:21];
  endfunction

  function automatic logic [4:0] instr_rt(input logic [31:0] w);
    return w[20:16];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] w);
    return w[15:11];
  endfunction

  function automatic logic [4:0] instr_shamt(input logic [31:0] w);
    return w[10:6];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] w);
    return w[5:0];
  endfunction

  // True for every function code the ALU implements.
  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FUNCT_SLL, FUNCT_SRL, FUNCT_MFHI, FUNCT_MFLO, FUNCT_MULT, FUNCT_DIV,
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
      FUNCT_SLT: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // Shifts take their data from rt and use the shamt field.
  function automatic logic funct_is_shift(input logic [5:0] f);
    return (f == FUNCT_SLL) || (f == FUNCT_SRL);
  endfunction

  // mult/div only touch hi/lo inside the ALU; everything else produces a value.
  function automatic logic funct_writes_back(input logic [5:0] f);
    return (f != FUNCT_MULT) && (f != FUNCT_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Instruction handshake, ALU drive/return and writeback bus of the issue sequencer.
// The slave modport is the sequencer; the master modport is fetch plus the ALU side.
interface alu_issue_seq_if;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err;
  logic        busy;

  modport slave (
    input  instr_valid, instr, alu_out,
    output instr_ready, alu_a, alu_b, alu_funct, alu_shamt,
           wb_valid, wb_addr, wb_data, err, busy
  );

  modport master (
    output instr_valid, instr, alu_out,
    input  instr_ready, alu_a, alu_b, alu_funct, alu_shamt,
           wb_valid, wb_addr, wb_data, err, busy
  );

endinterface

// File: rtl/alu_issue_seq_regfile.sv
// Register file for the issue sequencer: NREG x XLEN, three combinational
// read ports (rs, rt, debug), one synchronous write port, r0 fixed at zero.
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic [AW-1:0]   dbg_addr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREG];

  // Clear everything on reset; otherwise take one write per cycle, never into r0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
  assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue side of the ALU interface. Accepts R-type words, reads rs/rt,
// drives the ALU for exactly one cycle (one ALU negedge), then writes the
// result back to rd. Serial issue keeps mfhi/mflo ordered after mult/div.
// Optional feature macro: ALU_ISSUE_DIV0_CHECK_EN (reject div by zero at issue).
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter logic [5:0] PARK_FUNCT = FUNCT_PARK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_issue_seq_if.slave         bus,
  input  logic                   ld_en,
  input  logic [AW-1:0]          ld_addr,
  input  logic [XLEN-1:0]        ld_data,
  input  logic [AW-1:0]          dbg_addr,
  output logic [XLEN-1:0]        dbg_data
);

  state_t state, state_n;

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, shamt;
  logic [XLEN-1:0] rf_rs_data, rf_rt_data;
  logic [XLEN-1:0] rs_val, rt_val;
  logic            ld_act, div0, bad;
  logic            issue, reject;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      rd_q;
  logic            wb_en_q;

  assign op    = instr_op(bus.instr);
  assign rs    = instr_rs(bus.instr);
  assign rt    = instr_rt(bus.instr);
  assign rd    = instr_rd(bus.instr);
  assign shamt = instr_shamt(bus.instr);
  assign funct = instr_funct(bus.instr);

  seq_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs),
    .rt_addr  (rt),
    .dbg_addr (dbg_addr),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rs_data  (rf_rs_data),
    .rt_data  (rf_rt_data),
    .dbg_data (dbg_data)
  );

  // A preload landing on the same edge as an issue is ordered first, so the
  // operands see the preload value through this bypass.
  assign ld_act = (state == IDLE) && ld_en;
  assign rs_val = (ld_act && (ld_addr == rs) && (rs != '0)) ? ld_data : rf_rs_data;
  assign rt_val = (ld_act && (ld_addr == rt) && (rt != '0)) ? ld_data : rf_rt_data;

`ifdef ALU_ISSUE_DIV0_CHECK_EN
  assign div0 = (funct == FUNCT_DIV) && (rt_val == '0);
`else
  assign div0 = 1'b0;
`endif

  assign bad = (op != '0) || !funct_supported(funct) || div0;

  assign bus.instr_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, issue/reject decisions and the single regfile write port mux.
  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    reject   = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    case (state)
      IDLE: begin
        rf_we = ld_en;
        if (bus.instr_valid) begin
          if (bad) begin
            reject = 1'b1;
          end else begin
            issue   = 1'b1;
            state_n = EXEC;
          end
        end
      end
      EXEC: begin
        state_n = WB;
        if (wb_en_q) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = bus.alu_out;
        end
      end
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ALU drive registers, held for the EXEC cycle and parked afterwards, plus
  // the writeback and error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_shamt <= '0;
      bus.alu_funct <= PARK_FUNCT;
      bus.wb_valid  <= 1'b0;
      bus.wb_addr   <= '0;
      bus.wb_data   <= '0;
      bus.err       <= 1'b0;
      rd_q          <= '0;
      wb_en_q       <= 1'b0;
    end else begin
      bus.err      <= reject;
      bus.wb_valid <= 1'b0;
      if (issue) begin
        bus.alu_funct <= funct;
        bus.alu_b     <= rt_val;
        rd_q          <= rd;
        wb_en_q       <= funct_writes_back(funct);
        if (funct_is_shift(funct)) begin
          bus.alu_a     <= rt_val;
          bus.alu_shamt <= shamt;
        end else begin
          bus.alu_a     <= rs_val;
          bus.alu_shamt <= '0;
        end
      end
      if (state == EXEC) begin
        bus.alu_funct <= PARK_FUNCT;
        bus.wb_valid  <= wb_en_q;
        if (wb_en_q) begin
          bus.wb_addr <= rd_q;
          bus.wb_data <= bus.alu_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural negedge ALU.
module tb_alu_issue_seq;

  logic        clk;
  logic        rst_n;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] hi, lo;

  int compared;
  int mismatched;

  alu_issue_seq_if bus();

  alu_issue_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: evaluates on the falling edge, owns hi/lo.
  always @(negedge clk) begin
    logic [63:0] prod;
    case (bus.alu_funct)
      6'h00: bus.alu_out <= bus.alu_a << bus.alu_shamt;
      6'h02: bus.alu_out <= bus.alu_a >> bus.alu_shamt;
      6'h10: bus.alu_out <= hi;
      6'h12: bus.alu_out <= lo;
      6'h18: begin
        prod = {32'b0, bus.alu_a} * {32'b0, bus.alu_b};
        hi <= prod[63:32];
        lo <= prod[31:0];
        bus.alu_out <= 32'h0;
      end
      6'h1A: begin
        if (bus.alu_b != 0) begin
          lo <= bus.alu_a / bus.alu_b;
          hi <= bus.alu_a % bus.alu_b;
        end
        bus.alu_out <= 32'h0;
      end
      6'h20: bus.alu_out <= bus.alu_a + bus.alu_b;
      6'h22: bus.alu_out <= bus.alu_a - bus.alu_b;
      6'h24: bus.alu_out <= bus.alu_a & bus.alu_b;
      6'h25: bus.alu_out <= bus.alu_a | bus.alu_b;
      6'h26: bus.alu_out <= bus.alu_a ^ bus.alu_b;
      6'h27: bus.alu_out <= ~(bus.alu_a | bus.alu_b);
      6'h2A: bus.alu_out <= {31'b0, bus.alu_a < bus.alu_b};
      default: bus.alu_out <= 32'h0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic issue_instr(input logic [31:0] w);
    bus.instr_valid = 1'b1; bus.instr = w;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    preload(5'd7, 32'h1234);
    dbg_addr = 5'd7; #1;
    compared++; if (dbg_data !== 32'h1234) begin mismatched++; $display("[TB] FAIL reset_preload: got %h want %h", dbg_data, 32'h1234); end
    rst_n = 1'b0;
    tick(); tick();
    compared++; if (bus.alu_funct !== 6'h3F) begin mismatched++; $display("[TB] FAIL reset_funct: got %h want 3f", bus.alu_funct); end
    compared++; if ({bus.alu_a, bus.alu_b} !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_ab: got %h want 0", {bus.alu_a, bus.alu_b}); end
    compared++; if (bus.alu_shamt !== 5'h0) begin mismatched++; $display("[TB] FAIL reset_shamt: got %h want 0", bus.alu_shamt); end
    compared++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data, bus.err} !== 39'h0) begin mismatched++; $display("[TB] FAIL reset_wb_err: got %h want 0", {bus.wb_valid, bus.wb_addr, bus.wb_data, bus.err}); end
    compared++; if (dbg_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_regs: got %h want 0", dbg_data); end
    rst_n = 1'b1;
    tick();
    compared++; if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b/%b want 1/0", bus.instr_ready, bus.busy); end
  endtask

  task automatic test_add;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    issue_instr(32'h00221820);
    compared++; if ({bus.alu_a, bus.alu_b} !== {32'd5, 32'd7}) begin mismatched++; $display("[TB] FAIL add_operands: got %h want %h", {bus.alu_a, bus.alu_b}, {32'd5, 32'd7}); end
    compared++; if (bus.alu_funct !== 6'h20 || bus.instr_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL add_exec: got %h/%b want 20/0", bus.alu_funct, bus.instr_ready); end
    ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'h55;
    tick();
    ld_en = 1'b0;
    compared++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd3, 32'd12}) begin mismatched++; $display("[TB] FAIL add_wb: got %b %0d %h want 1 3 c", bus.wb_valid, bus.wb_addr, bus.wb_data); end
    compared++; if (bus.alu_funct !== 6'h3F) begin mismatched++; $display("[TB] FAIL add_park: got %h want 3f", bus.alu_funct); end
    tick();
    compared++; if (bus.wb_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL add_idle: got %b/%b want 0/1", bus.wb_valid, bus.instr_ready); end
    dbg_addr = 5'd3; #1;
    compared++; if (dbg_data !== 32'd12) begin mismatched++; $display("[TB] FAIL add_r3: got %h want c", dbg_data); end
    dbg_addr = 5'd10; #1;
    compared++; if (dbg_data !== 32'h0) begin mismatched++; $display("[TB] FAIL add_ld_in_exec: got %h want 0", dbg_data); end
  endtask

  task automatic test_sll;
    preload(5'd1, 32'h1);
    issue_instr(32'h00012100);
    compared++; if (bus.alu_a !== 32'h1 || bus.alu_shamt !== 5'd4 || bus.alu_funct !== 6'h00) begin mismatched++; $display("[TB] FAIL sll_exec: got %h %0d %h want 1 4 00", bus.alu_a, bus.alu_shamt, bus.alu_funct); end
    tick();
    compared++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd4, 32'h10}) begin mismatched++; $display("[TB] FAIL sll_wb: got %b %0d %h want 1 4 10", bus.wb_valid, bus.wb_addr, bus.wb_data); end
    tick();
    dbg_addr = 5'd4; #1;
    compared++; if (dbg_data !== 32'h10) begin mismatched++; $display("[TB] FAIL sll_r4: got %h want 10", dbg_data); end
  endtask

  task automatic test_mult_hilo;
    preload(5'd1, 32'h10000);
    preload(5'd2, 32'h10000);
    preload(5'd6, 32'hDEAD);
    issue_instr(32'h00220018);
    tick();
    compared++; if (bus.wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mult_no_wb: got %b want 0", bus.wb_valid); end
    tick();
    issue_instr(32'h00002810);
    tick();
    compared++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd5, 32'd1}) begin mismatched++; $display("[TB] FAIL mfhi_wb: got %b %0d %h want 1 5 1", bus.wb_valid, bus.wb_addr, bus.wb_data); end
    tick();
    issue_instr(32'h00003012);
    tick();
    compared++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd6, 32'd0}) begin mismatched++; $display("[TB] FAIL mflo_wb: got %b %0d %h want 1 6 0", bus.wb_valid, bus.wb_addr, bus.wb_data); end
    tick();
    dbg_addr = 5'd5; #1;
    compared++; if (dbg_data !== 32'd1) begin mismatched++; $display("[TB] FAIL mfhi_r5: got %h want 1", dbg_data); end
    dbg_addr = 5'd6; #1;
    compared++; if (dbg_data !== 32'd0) begin mismatched++; $display("[TB] FAIL mflo_r6: got %h want 0", dbg_data); end
  endtask

  task automatic test_reject;
    logic [31:0] bad_words [2];
    bad_words[0] = 32'h20221820;
    bad_words[1] = 32'h00221803;
    preload(5'd3, 32'hABCD);
    for (int i = 0; i < 2; i++) begin
      issue_instr(bad_words[i]);
      compared++; if (bus.err !== 1'b1 || bus.instr_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reject_err_%0d: got %b/%b want 1/1", i, bus.err, bus.instr_ready); end
      compared++; if (bus.alu_funct !== 6'h3F || bus.wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reject_quiet_%0d: got %h/%b want 3f/0", i, bus.alu_funct, bus.wb_valid); end
      tick();
      compared++; if (bus.err !== 1'b0 || bus.wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reject_pulse_%0d: got %b/%b want 0/0", i, bus.err, bus.wb_valid); end
    end
    dbg_addr = 5'd3; #1;
    compared++; if (dbg_data !== 32'hABCD) begin mismatched++; $display("[TB] FAIL reject_r3: got %h want abcd", dbg_data); end
  endtask

  task automatic test_div;
    preload(5'd1, 32'd7);
    preload(5'd2, 32'd0);
    issue_instr(32'h0022001A);
`ifdef ALU_ISSUE_DIV0_CHECK_EN
    compared++; if (bus.err !== 1'b1 || bus.alu_funct !== 6'h3F) begin mismatched++; $display("[TB] FAIL div0_reject: got %b/%h want 1/3f", bus.err, bus.alu_funct); end
    tick();
    compared++; if (bus.err !== 1'b0 || bus.instr_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL div0_after: got %b/%b want 0/1", bus.err, bus.instr_ready); end
`else
    compared++; if (bus.err !== 1'b0 || bus.alu_funct !== 6'h1A) begin mismatched++; $display("[TB] FAIL div0_issue: got %b/%h want 0/1a", bus.err, bus.alu_funct); end
    tick();
    compared++; if (bus.wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL div0_no_wb: got %b want 0", bus.wb_valid); end
    tick();
`endif
    preload(5'd2, 32'd2);
    issue_instr(32'h0022001A);
    tick(); tick();
    issue_instr(32'h00003812);
    tick();
    compared++; if (bus.wb_data !== 32'd3 || bus.wb_addr !== 5'd7) begin mismatched++; $display("[TB] FAIL div_mflo: got %h@%0d want 3@7", bus.wb_data, bus.wb_addr); end
    tick();
    issue_instr(32'h00004010);
    tick();
    compared++; if (bus.wb_data !== 32'd1 || bus.wb_addr !== 5'd8) begin mismatched++; $display("[TB] FAIL div_mfhi: got %h@%0d want 1@8", bus.wb_data, bus.wb_addr); end
    tick();
  endtask

  task automatic test_preload_fwd;
    preload(5'd2, 32'd1);
    bus.instr_valid = 1'b1; bus.instr = 32'h00221820;
    ld_en = 1'b1; ld_addr = 5'd1; ld_data = 32'd100;
    tick();
    bus.instr_valid = 1'b0; ld_en = 1'b0;
    compared++; if ({bus.alu_a, bus.alu_b} !== {32'd100, 32'd1}) begin mismatched++; $display("[TB] FAIL fwd_operands: got %h want %h", {bus.alu_a, bus.alu_b}, {32'd100, 32'd1}); end
    tick();
    compared++; if (bus.wb_data !== 32'd101) begin mismatched++; $display("[TB] FAIL fwd_wb: got %h want 65", bus.wb_data); end
    tick();
    dbg_addr = 5'd1; #1;
    compared++; if (dbg_data !== 32'd100) begin mismatched++; $display("[TB] FAIL fwd_r1: got %h want 64", dbg_data); end
  endtask

  task automatic test_back_to_back;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    bus.instr_valid = 1'b1; bus.instr = 32'h00221820;
    tick();
    bus.instr = 32'h00220022;
    compared++; if (bus.alu_funct !== 6'h20 || bus.instr_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_first: got %h/%b want 20/0", bus.alu_funct, bus.instr_ready); end
    tick();
    compared++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd12 || bus.instr_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_wb1: got %b %h %b want 1 c 0", bus.wb_valid, bus.wb_data, bus.instr_ready); end
    tick();
    compared++; if (bus.instr_ready !== 1'b1 || bus.alu_funct !== 6'h3F) begin mismatched++; $display("[TB] FAIL b2b_gap: got %b/%h want 1/3f", bus.instr_ready, bus.alu_funct); end
    tick();
    bus.instr_valid = 1'b0;
    compared++; if (bus.alu_funct !== 6'h22 || bus.alu_a !== 32'd5) begin mismatched++; $display("[TB] FAIL b2b_second: got %h/%h want 22/5", bus.alu_funct, bus.alu_a); end
    tick();
    compared++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd0, 32'hFFFFFFFE}) begin mismatched++; $display("[TB] FAIL b2b_r0_wb: got %b %0d %h want 1 0 fffffffe", bus.wb_valid, bus.wb_addr, bus.wb_data); end
    tick();
    dbg_addr = 5'd0; #1;
    compared++; if (dbg_data !== 32'h0) begin mismatched++; $display("[TB] FAIL b2b_r0: got %h want 0", dbg_data); end
  endtask

  task automatic test_reset_mid_exec;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    issue_instr(32'h00224820);
    compared++; if (bus.instr_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_in_exec: got %b want 0", bus.instr_ready); end
    rst_n = 1'b0;
    tick();
    compared++; if (bus.instr_ready !== 1'b1 || bus.alu_funct !== 6'h3F || bus.wb_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_state: got %b %h %b want 1 3f 0", bus.instr_ready, bus.alu_funct, bus.wb_valid); end
    dbg_addr = 5'd1; #1;
    compared++; if (dbg_data !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_r1: got %h want 0", dbg_data); end
    rst_n = 1'b1;
    tick();
    dbg_addr = 5'd9; #1;
    compared++; if (bus.wb_valid !== 1'b0 || dbg_data !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_r9: got %b/%h want 0/0", bus.wb_valid, dbg_data); end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    clk = 1'b0; rst_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.alu_out = '0;
    hi = '0; lo = '0;
    tick(); tick();
    test_reset();
    test_add();
    test_sll();
    test_mult_hilo();
    test_reject();
    test_div();
    test_preload_fwd();
    test_back_to_back();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
